// File: rtl/call_scheduler.sv
// Floor-call scheduler: debounces three call buttons, keeps a pending call per floor and
// hands one target floor at a time to the movement stage over a 4-phase handshake.
module call_scheduler #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic       floor1,
    input  logic       floor2,
    input  logic       floor3,
    input  logic       door,
    input  logic       sos_mode,
    input  logic       target_ack,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic       target_valid,
    output logic [1:0] target_floor,
    output logic       dir_up
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SELECT, REQ, RELEASE} state_t;

    logic [8:0]    raw;
    logic [8:0]    sync1;
    logic [8:0]    sync2;
    logic [2:0]    btn_s;
    logic [2:0]    floor_s;
    logic          door_s;
    logic          sos_s;
    logic          ack_s;

    logic [CW-1:0] cnt [3];
    logic [2:0]    deb;
    logic [2:0]    deb_prev;
    logic [2:0]    at_floor;
    logic [2:0]    press;
    logic [2:0]    pending;
    logic [1:0]    last_floor;

    logic          up_found;
    logic          dn_found;
    logic [1:0]    up_floor;
    logic [1:0]    dn_floor;
    logic [1:0]    sel_floor;
    logic          sel_dir;

    state_t        state;
    state_t        next_state;

    assign raw     = {target_ack, sos_mode, door, floor3, floor2, floor1, button3, button2, button1};
    assign btn_s   = sync2[2:0];
    assign floor_s = sync2[5:3];
    assign door_s  = sync2[6];
    assign sos_s   = sync2[7];
    assign ack_s   = sync2[8];

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
            deb      <= '0;
            deb_prev <= '0;
        end else begin
            deb_prev <= deb;
            for (int i = 0; i < 3; i++) begin
                if (btn_s[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i] <= '0;
                    deb[i] <= btn_s[i];
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign at_floor = floor_s & {3{door_s}};
    assign press    = deb & ~deb_prev & ~at_floor;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (sos_s) begin
            pending <= '0;
        end else begin
            pending <= (pending | press) & ~at_floor;
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            last_floor <= 2'd1;
        end else begin
            case (floor_s)
                3'b001:  last_floor <= 2'd1;
                3'b010:  last_floor <= 2'd2;
                3'b100:  last_floor <= 2'd3;
                default: last_floor <= last_floor;
            endcase
        end
    end

    // Nearest pending floor above and below the last known car position.
    always_comb begin
        up_found = 1'b0;
        up_floor = 2'd1;
        dn_found = 1'b0;
        dn_floor = 2'd1;
        case (last_floor)
            2'd1: begin
                if (pending[1]) begin
                    up_found = 1'b1;
                    up_floor = 2'd2;
                end else if (pending[2]) begin
                    up_found = 1'b1;
                    up_floor = 2'd3;
                end
            end
            2'd2: begin
                if (pending[2]) begin
                    up_found = 1'b1;
                    up_floor = 2'd3;
                end
                if (pending[0]) begin
                    dn_found = 1'b1;
                    dn_floor = 2'd1;
                end
            end
            default: begin
                if (pending[1]) begin
                    dn_found = 1'b1;
                    dn_floor = 2'd2;
                end else if (pending[0]) begin
                    dn_found = 1'b1;
                    dn_floor = 2'd1;
                end
            end
        endcase
    end

    always_comb begin
        sel_floor = last_floor;
        sel_dir   = dir_up;
        if (dir_up) begin
            if (up_found) begin
                sel_floor = up_floor;
            end else if (dn_found) begin
                sel_floor = dn_floor;
                sel_dir   = 1'b0;
            end
        end else begin
            if (dn_found) begin
                sel_floor = dn_floor;
            end else if (up_found) begin
                sel_floor = up_floor;
                sel_dir   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Emergency mode forces every state to RELEASE and holds it there until both it and ack drop.
    always_comb begin
        next_state   = state;
        target_valid = 1'b0;
        case (state)
            IDLE: begin
                if (sos_s) begin
                    next_state = RELEASE;
                end else if (|pending) begin
                    next_state = SELECT;
                end
            end
            SELECT: begin
                if (sos_s) begin
                    next_state = RELEASE;
                end else if (|pending) begin
                    next_state = REQ;
                end else begin
                    next_state = IDLE;
                end
            end
            REQ: begin
                target_valid = 1'b1;
                if (sos_s || ack_s) begin
                    next_state = RELEASE;
                end
            end
            RELEASE: begin
                if (!ack_s && !sos_s) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            target_floor <= 2'd1;
            dir_up       <= 1'b1;
        end else if (state == SELECT && next_state == REQ) begin
            target_floor <= sel_floor;
            dir_up       <= sel_dir;
        end
    end

    assign led1 = pending[0];
    assign led2 = pending[1];
    assign led3 = pending[2];

endmodule

// File: tb/tb_call_scheduler.sv
// Bench for call_scheduler: directed scenarios plus random call patterns served by a
// behavioural car model that predicts each target from the sweep rules.
`timescale 1ns/1ps
module tb_call_scheduler;

    localparam int DB = 4;

    logic       clk_50 = 1'b0;
    logic       rst_n;
    logic       button1, button2, button3;
    logic       floor1, floor2, floor3;
    logic       door, sos_mode, target_ack;
    logic       led1, led2, led3;
    logic       target_valid;
    logic [1:0] target_floor;
    logic       dir_up;

    int         total = 0;
    int         bad = 0;

    logic [3:1] m_pend;
    int         m_last;
    int         m_car;
    logic       m_dir;

    call_scheduler #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk_50       (clk_50),
        .rst_n        (rst_n),
        .button1      (button1),
        .button2      (button2),
        .button3      (button3),
        .floor1       (floor1),
        .floor2       (floor2),
        .floor3       (floor3),
        .door         (door),
        .sos_mode     (sos_mode),
        .target_ack   (target_ack),
        .led1         (led1),
        .led2         (led2),
        .led3         (led3),
        .target_valid (target_valid),
        .target_floor (target_floor),
        .dir_up       (dir_up)
    );

    always #10 clk_50 = ~clk_50;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    task automatic set_floor(input int f);
        m_car  = f;
        floor1 = (f == 1);
        floor2 = (f == 2);
        floor3 = (f == 3);
    endtask

    task automatic apply_reset(input int car);
        rst_n      = 1'b0;
        button1    = 1'b0;
        button2    = 1'b0;
        button3    = 1'b0;
        door       = 1'b0;
        sos_mode   = 1'b0;
        target_ack = 1'b0;
        set_floor(car);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        m_pend = '0;
        m_last = car;
        m_dir  = 1'b1;
    endtask

    // Sweep rule: keep going while something lies ahead, otherwise turn around.
    function automatic void ref_select(input logic [3:1] p, input int c, input logic d,
                                       output int tgt, output logic nd);
        int above = 0;
        int below = 0;
        for (int f = 3; f > c; f--) if (p[f]) above = f;
        for (int f = 1; f < c; f++) if (p[f]) below = f;
        tgt = c;
        nd  = d;
        if (d) begin
            if (above != 0) tgt = above;
            else if (below != 0) begin tgt = below; nd = 1'b0; end
        end else begin
            if (below != 0) tgt = below;
            else if (above != 0) begin tgt = above; nd = 1'b1; end
        end
    endfunction

    task automatic press(input logic [3:1] b);
        for (int f = 1; f <= 3; f++) begin
            if (b[f] && !(door && m_car == f)) m_pend[f] = 1'b1;
        end
        button1 = b[1];
        button2 = b[2];
        button3 = b[3];
        tick(10);
        button1 = 1'b0;
        button2 = 1'b0;
        button3 = 1'b0;
        tick(8);
    endtask

    task automatic serve_one();
        int   tgt;
        logic nd;
        int   n;
        ref_select(m_pend, m_last, m_dir, tgt, nd);
        n = 0;
        while (target_valid !== 1'b1 && n < 30) begin tick(1); n++; end
        total++;
        if (target_valid !== 1'b1) begin bad++; $display("[TB] FAIL serve_valid: got %b want 1", target_valid); end
        total++;
        if (target_floor !== 2'(tgt)) begin bad++; $display("[TB] FAIL serve_floor: got %0d want %0d", target_floor, tgt); end
        total++;
        if (dir_up !== nd) begin bad++; $display("[TB] FAIL serve_dir: got %b want %b", dir_up, nd); end
        target_ack = 1'b1;
        n = 0;
        while (target_valid !== 1'b0 && n < 30) begin tick(1); n++; end
        total++;
        if (target_valid !== 1'b0) begin bad++; $display("[TB] FAIL serve_release: got %b want 0", target_valid); end
        set_floor(tgt);
        door = 1'b1;
        tick(4);
        m_pend[tgt] = 1'b0;
        m_last = tgt;
        m_dir  = nd;
        total++;
        if ({led3, led2, led1} !== m_pend) begin bad++; $display("[TB] FAIL serve_leds: got %b want %b", {led3, led2, led1}, m_pend); end
        door       = 1'b0;
        target_ack = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        button1    = 1'b0;
        button2    = 1'b0;
        button3    = 1'b0;
        door       = 1'b0;
        sos_mode   = 1'b0;
        target_ack = 1'b0;
        set_floor(1);
        tick(2);
        total++;
        if ({led3, led2, led1} !== 3'b000) begin bad++; $display("[TB] FAIL reset_leds: got %b want 000", {led3, led2, led1}); end
        total++;
        if (target_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", target_valid); end
        total++;
        if (target_floor !== 2'd1) begin bad++; $display("[TB] FAIL reset_floor: got %0d want 1", target_floor); end
        total++;
        if (dir_up !== 1'b1) begin bad++; $display("[TB] FAIL reset_dir: got %b want 1", dir_up); end
        rst_n = 1'b1;
        tick(5);
        total++;
        if (target_valid !== 1'b0 || {led3, led2, led1} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_idle: got valid=%b leds=%b want 0/000", target_valid, {led3, led2, led1});
        end
    endtask

    task automatic test_glitch();
        apply_reset(1);
        button2 = 1'b1;
        tick(3);
        button2 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            total++;
            if (led2 !== 1'b0 || target_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL glitch_cycle%0d: got led2=%b valid=%b want 0/0", i, led2, target_valid);
            end
        end
    endtask

    task automatic test_press_latency();
        apply_reset(1);
        button3 = 1'b1;
        tick(6);
        total++;
        if (led3 !== 1'b0) begin bad++; $display("[TB] FAIL led3_early: got %b want 0", led3); end
        tick(1);
        total++;
        if (led3 !== 1'b1) begin bad++; $display("[TB] FAIL led3_on: got %b want 1", led3); end
        total++;
        if (target_valid !== 1'b0) begin bad++; $display("[TB] FAIL valid_early: got %b want 0", target_valid); end
        tick(1);
        total++;
        if (target_valid !== 1'b0) begin bad++; $display("[TB] FAIL valid_select: got %b want 0", target_valid); end
        tick(1);
        total++;
        if (target_valid !== 1'b1 || target_floor !== 2'd3 || dir_up !== 1'b1) begin
            bad++;
            $display("[TB] FAIL first_req: got valid=%b floor=%0d dir=%b want 1/3/1", target_valid, target_floor, dir_up);
        end
        tick(1);
        button3 = 1'b0;
        m_pend  = 3'b100;
    endtask

    task automatic test_handshake();
        target_ack = 1'b1;
        tick(2);
        total++;
        if (target_valid !== 1'b1) begin bad++; $display("[TB] FAIL ack_hold: got %b want 1", target_valid); end
        tick(1);
        total++;
        if (target_valid !== 1'b0) begin bad++; $display("[TB] FAIL ack_drop: got %b want 0", target_valid); end
        target_ack = 1'b0;
        tick(4);
        total++;
        if (target_valid !== 1'b0) begin bad++; $display("[TB] FAIL rereq_early: got %b want 0", target_valid); end
        tick(1);
        total++;
        if (target_valid !== 1'b1 || target_floor !== 2'd3) begin
            bad++;
            $display("[TB] FAIL rereq: got valid=%b floor=%0d want 1/3", target_valid, target_floor);
        end
        set_floor(3);
        door = 1'b1;
        tick(2);
        total++;
        if (led3 !== 1'b1) begin bad++; $display("[TB] FAIL led3_hold: got %b want 1", led3); end
        tick(1);
        total++;
        if (led3 !== 1'b0) begin bad++; $display("[TB] FAIL led3_clear: got %b want 0", led3); end
        target_ack = 1'b1;
        tick(3);
        total++;
        if (target_valid !== 1'b0) begin bad++; $display("[TB] FAIL ack2_drop: got %b want 0", target_valid); end
        door       = 1'b0;
        target_ack = 1'b0;
        tick(8);
        total++;
        if (target_valid !== 1'b0 || {led3, led2, led1} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL handshake_idle: got valid=%b leds=%b want 0/000", target_valid, {led3, led2, led1});
        end
    endtask

    task automatic test_direction();
        apply_reset(2);
        press(3'b101);
        total++;
        if (target_valid !== 1'b1 || target_floor !== 2'd3 || dir_up !== 1'b1) begin
            bad++;
            $display("[TB] FAIL dir_keep_up: got valid=%b floor=%0d dir=%b want 1/3/1", target_valid, target_floor, dir_up);
        end
        for (int k = 0; k < 3 && m_pend != 3'b000; k++) serve_one();
        apply_reset(2);
        press(3'b001);
        total++;
        if (target_valid !== 1'b1 || target_floor !== 2'd1 || dir_up !== 1'b0) begin
            bad++;
            $display("[TB] FAIL dir_turn: got valid=%b floor=%0d dir=%b want 1/1/0", target_valid, target_floor, dir_up);
        end
    endtask

    task automatic test_sos();
        apply_reset(3);
        press(3'b010);
        total++;
        if (target_valid !== 1'b1 || target_floor !== 2'd2 || dir_up !== 1'b0) begin
            bad++;
            $display("[TB] FAIL sos_pre_req: got valid=%b floor=%0d dir=%b want 1/2/0", target_valid, target_floor, dir_up);
        end
        sos_mode = 1'b1;
        tick(3);
        total++;
        if (target_valid !== 1'b0 || {led3, led2, led1} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL sos_drop: got valid=%b leds=%b want 0/000", target_valid, {led3, led2, led1});
        end
        button2 = 1'b1;
        button3 = 1'b1;
        tick(12);
        total++;
        if ({led3, led2, led1} !== 3'b000) begin bad++; $display("[TB] FAIL sos_press: got %b want 000", {led3, led2, led1}); end
        button2 = 1'b0;
        button3 = 1'b0;
        tick(8);
        sos_mode = 1'b0;
        tick(10);
        total++;
        if (target_valid !== 1'b0 || {led3, led2, led1} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL sos_after: got valid=%b leds=%b want 0/000", target_valid, {led3, led2, led1});
        end
    endtask

    task automatic test_reset_mid_req();
        apply_reset(3);
        press(3'b010);
        total++;
        if (target_valid !== 1'b1 || led2 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_pre_req: got valid=%b led2=%b want 1/1", target_valid, led2);
        end
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({led3, led2, led1} !== 3'b000 || target_valid !== 1'b0 || target_floor !== 2'd1 || dir_up !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_reset: got leds=%b valid=%b floor=%0d dir=%b want 000/0/1/1",
                     {led3, led2, led1}, target_valid, target_floor, dir_up);
        end
        tick(2);
        rst_n = 1'b1;
        tick(10);
        total++;
        if (target_valid !== 1'b0 || {led3, led2, led1} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL mid_after: got valid=%b leds=%b want 0/000", target_valid, {led3, led2, led1});
        end
    endtask

    task automatic test_random();
        logic [3:1] b;
        apply_reset(1);
        for (int it = 0; it < 12; it++) begin
            b    = 3'($urandom_range(1, 7));
            door = ($urandom_range(0, 3) == 0);
            press(b);
            door = 1'b0;
            total++;
            if ({led3, led2, led1} !== m_pend) begin
                bad++;
                $display("[TB] FAIL rand_leds it%0d: got %b want %b", it, {led3, led2, led1}, m_pend);
            end
            for (int k = 0; k < 3 && m_pend != 3'b000; k++) serve_one();
            tick(4);
            total++;
            if (target_valid !== 1'b0) begin bad++; $display("[TB] FAIL rand_idle it%0d: got %b want 0", it, target_valid); end
        end
    endtask

    initial begin
        $display("[TB] call_scheduler bench start");
        test_reset();
        test_glitch();
        test_press_latency();
        test_handshake();
        test_direction();
        test_sos();
        test_reset_mid_req();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/call_scheduler.md
CALL_SCHEDULER -- requirements
Module: call_scheduler

Interface
REQ-001 The block SHALL have one parameter: DEBOUNCE_CYCLES, default 500000, the number of consecutive stable clk_50 cycles (10 ms at 50 MHz) required to accept a button level change.
REQ-002 clk_50  input  1  board clock; the only clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 button1, button2, button3  input  1 each  raw, bouncy, active-high floor call buttons.
REQ-005 floor1, floor2, floor3  input  1 each  one-hot current car position from the movement stage; asynchronous to clk_50.
REQ-006 door  input  1  high while the car door is open; asynchronous.
REQ-007 sos_mode  input  1  high while emergency mode is active; asynchronous.
REQ-008 target_ack  input  1  4-phase acknowledge from the movement stage; asynchronous.
REQ-009 led1, led2, led3  output  1 each  pending call per floor.
REQ-010 target_valid  output  1  4-phase request: target_floor is valid.
REQ-011 target_floor  output  2  requested floor, encoded 1..3; 0 is never driven.
REQ-012 dir_up  output  1  current sweep direction; 1 = up.

Function
REQ-013 Every asynchronous input SHALL pass through a 2-flop synchronizer before any use; all timing below counts from the synchronized value.
REQ-014 Per button, a debounce counter SHALL update the debounced level only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any cycle of agreement SHALL clear the counter.
REQ-015 A rising edge of debounced button n SHALL set pending[n] (driven on led n) on the next cycle, except when floorn=1 and door=1, in which case the press is ignored.
REQ-016 pending[n] SHALL clear on the cycle after synchronized floorn=1 and door=1 are seen together; when a set and a clear coincide, clear wins.
REQ-017 A last-floor register SHALL track the synchronized one-hot floor input; it holds its value when the input is all-zero or has more than one bit set.
REQ-018 The FSM SHALL have states IDLE, SELECT, REQ and RELEASE.
REQ-019 IDLE -> SELECT when any pending bit is set and sos_mode is low; otherwise the FSM stays in IDLE.
REQ-020 SELECT SHALL last exactly one cycle and register target_floor, then go to REQ; selection uses last floor c:
- dir_up=1: lowest pending floor above c.
- dir_up=0: highest pending floor below c.
- If no pending floor lies in the current direction: toggle dir_up and take the nearest pending floor in the new direction.
- If only c itself is pending: target_floor=c, dir_up unchanged.
REQ-021 In REQ, target_valid=1, and target_floor and dir_up SHALL be held stable until synchronized target_ack=1, then the FSM goes to RELEASE.
REQ-022 In RELEASE, target_valid=0; the FSM returns to IDLE when synchronized target_ack=0.
REQ-023 A request SHALL NOT be withdrawn in REQ because its pending bit clears; the only withdrawal is by sos_mode.
REQ-024 While synchronized sos_mode=1:
- all pending bits SHALL clear and new presses SHALL be ignored;
- target_valid SHALL drop on the next cycle;
- the FSM SHALL move from any state to RELEASE.
Debounce counters keep running during sos_mode.
REQ-025 Press-to-led latency from the raw button SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles; led-to-target_valid latency SHALL be 2 cycles (IDLE, SELECT).

Reset
REQ-026 While rst_n=0, immediately and regardless of clock:
- led1..3=0, target_valid=0, target_floor=1, dir_up=1;
- FSM=IDLE, last floor=1;
- debounced levels, debounce counters and synchronizers cleared.
REQ-027 After rst_n deasserts, operation SHALL resume on the first rising clk_50 edge; an rst_n pulse mid-handshake SHALL abandon the request without waiting for target_ack.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 3-cycle glitch on button2 -> led2 stays 0 and target_valid stays 0.
REQ-029 floor1=1, door=0, button3 held 10 cycles -> led3=1 seven cycles after the press; target_valid=1 two cycles later with target_floor=3, dir_up=1.
REQ-030 Handshake: target_ack high -> target_valid low 3 cycles later; target_ack low -> FSM back in IDLE; then floor3=1 and door=1 -> led3 clears 3 cycles later.
REQ-031 At floor2 with dir_up=1 and pending {1,3} -> target_floor=3. With pending {1} only -> dir_up=0, target_floor=1.
REQ-032 sos_mode raised during REQ -> led1..3=0 and target_valid=0 within 3 cycles; button presses while sos_mode=1 leave led1..3 at 0.
REQ-033 rst_n pulled low during REQ with target_ack=0 -> all outputs at reset values at once, FSM in IDLE after release.
